controlador_turnos: RTL
=======================

Name: controlador_turnos

Overview:
- Synchronous game sequencer for the tic-tac-toe board. It grants turns to player 1 and player 2 and accepts cell-selection requests from the cursor/selector logic. It validates each request against the board it owns, applies a per-turn timeout, and detects win/draw.
- Drives the turn inputs of the cell selector and supplies the stored board to the display/VGA path.

Parameters:
- T_TURNO, 250000000, cycles allowed per turn before the turn passes (5 s at 50 MHz); must be >= 2
- CNT_W, 28, width of turn timer; must satisfy 2^CNT_W > T_TURNO

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- iniciar  input  1  one-cycle pulse; starts or restarts a game
- jugada_valida  input  1  one-cycle pulse; a cell has been chosen
- jugada_cuadro  input  4  chosen cell, 1..9 row-major (1 top-left, 9 bottom-right)
- turno_p1  output  1  player 1 owns the turn
- turno_p2  output  1  player 2 owns the turn
- tablero  output  18  board; cell k at bits [2k-1:2k-2]; 00 empty, 11 player 1, 01 player 2
- jugadas  output  4  count of occupied cells, 0..9
- jugada_rechazada  output  1  one-cycle pulse; request refused
- tiempo_agotado  output  1  one-cycle pulse; turn lost to timeout
- fin_juego  output  1  high while game over
- ganador  output  2  00 none, 11 player 1, 01 player 2, 10 draw

Behaviour:
- All outputs registered. Reset state: ESPERA, tablero=0, jugadas=0, turno_p1=turno_p2=0, jugada_rechazada=0, tiempo_agotado=0, fin_juego=0, ganador=00, timer=0.
- States: ESPERA, TURNO_P1, TURNO_P2, EVALUA, FIN. turno_p1=1 only in TURNO_P1 and turno_p2=1 only in TURNO_P2; never both high at once.
- ESPERA: iniciar -> TURNO_P1 on next edge. tablero, jugadas, ganador and timer are cleared on that edge.
- TURNO_Px, jugada_valida with jugada_cuadro in 1..9 and the cell at 00:
  - Cell is written (11 for P1, 01 for P2) and jugadas increments on the same edge.
  - FSM moves to EVALUA and records the mover.
- TURNO_Px, jugada_valida with jugada_cuadro 0 or 10..15, or cell occupied:
  - jugada_rechazada=1 for exactly one cycle.
  - State, board and timer are unchanged; the timer keeps counting.
- TURNO_Px timer increments each cycle. When timer==T_TURNO-1 and no accepted move in that cycle:
  - FSM switches to the other player's TURNO and the timer is cleared.
  - tiempo_agotado=1 for one cycle. The board is unchanged.
- Accepted move on the same cycle as timeout: the move wins and tiempo_agotado is not pulsed.
- EVALUA (exactly one cycle; both turno outputs 0):
  - Check the 8 lines (3 rows, 3 columns, 2 diagonals) for the mover's code.
  - Win -> FIN with ganador = mover code.
  - Else jugadas==9 -> FIN with ganador=10.
  - Else -> other player's TURNO with timer cleared.
- Latency: move accepted at edge N -> tablero visible after edge N; next turn or FIN after edge N+1.
- FIN: fin_juego=1. tablero and ganador hold. iniciar -> cleared board, fin_juego=0, TURNO_P1.
- iniciar in TURNO_P1, TURNO_P2 or EVALUA restarts the game the same way as from FIN; a simultaneous jugada_valida is dropped, with no rejection pulse.
- jugada_valida in ESPERA, EVALUA or FIN is ignored, with no rejection pulse.
- Player 1 always opens a game.
- Reset asserted mid-game returns everything to reset values asynchronously. After release, the FSM waits in ESPERA for iniciar.

Test Plan:
- reset, iniciar, moves P1:5, P2:1, P1:3, P2:9, P1:7 -> P1 completes diagonal 3-5-7. After the last EVALUA, fin_juego=1, ganador=11, tablero[9:8]=11, both turno outputs 0.
- Full draw sequence 1,2,3,5,4,6,8,7,9 (alternating P1/P2) -> after the 9th move, jugadas=9, ganador=10, fin_juego=1.
- In TURNO_P2, request occupied cell 5, then cell 0, then cell 12 -> three single-cycle jugada_rechazada pulses, turno_p2 stays 1, tablero unchanged.
- T_TURNO=8, no move after iniciar -> tiempo_agotado pulses 8 cycles after TURNO_P1 entry and turno_p2=1 next. A move on the exact timeout cycle is accepted instead, with no pulse.
- iniciar and jugada_valida in the same cycle during TURNO_P1 with 3 cells filled -> tablero=0, jugadas=0, turno_p1=1, no write.
- Assert reset in EVALUA and in FIN -> all outputs at reset values before the next edge. jugada_valida is ignored until iniciar.

Source files
------------

// File: rtl/controlador_turnos.sv
// controlador_turnos: tic-tac-toe turn sequencer owning the board.
// Grants turns, validates cell requests, times turns out, and detects win/draw.
// Ports:
//   clk, reset (async, active-high)
//   iniciar           start/restart pulse
//   jugada_valida     cell-chosen pulse
//   jugada_cuadro     cell 1..9
//   turno_p1/turno_p2 turn owner
//   tablero           2 bits per cell (11 P1, 01 P2)
//   jugadas           occupied cell count
//   jugada_rechazada  refused request pulse
//   tiempo_agotado    turn-timeout pulse
//   fin_juego         game over level
//   ganador           00 none, 11 P1, 01 P2, 10 draw
module controlador_turnos #(
    parameter int unsigned T_TURNO = 250000000,
    parameter int          CNT_W   = 28
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        jugada_valida,
    input  logic [3:0]  jugada_cuadro,
    output logic        turno_p1,
    output logic        turno_p2,
    output logic [17:0] tablero,
    output logic [3:0]  jugadas,
    output logic        jugada_rechazada,
    output logic        tiempo_agotado,
    output logic        fin_juego,
    output logic [1:0]  ganador
);

    typedef enum logic [2:0] {
        ESPERA,
        TURNO_P1,
        TURNO_P2,
        EVALUA,
        FIN
    } estado_t;

    estado_t          estado;
    logic [1:0]       mover;
    logic [CNT_W-1:0] timer;

    logic [1:0] codigo;
    logic [1:0] celda;
    logic       cuadro_ok;
    logic       acepta;
    logic       fin_turno;

    // Any of the 8 lines fully owned by code c.
    function automatic logic gana(input logic [17:0] t,
                                  input logic [1:0]  c);
        logic [8:0] m;
        for (int i = 0; i < 9; i++) begin
            m[i] = (t[2*i +: 2] == c);
        end
        return (&m[2:0]) | (&m[5:3]) | (&m[8:6])
             | (m[0] & m[3] & m[6])
             | (m[1] & m[4] & m[7])
             | (m[2] & m[5] & m[8])
             | (m[0] & m[4] & m[8])
             | (m[2] & m[4] & m[6]);
    endfunction

    assign codigo    = (estado == TURNO_P1) ? 2'b11 : 2'b01;
    assign cuadro_ok = (jugada_cuadro >= 4'd1) && (jugada_cuadro <= 4'd9);
    assign acepta    = jugada_valida && cuadro_ok && (celda == 2'b00);
    assign fin_turno = (timer == CNT_W'(T_TURNO - 1));

    // Contents of the requested cell; out-of-range requests read as empty
    // but are refused through cuadro_ok.
    always_comb begin
        celda = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            if (jugada_cuadro == 4'(k)) celda = tablero[2*k-2 +: 2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado           <= ESPERA;
            mover            <= 2'b00;
            timer            <= '0;
            tablero          <= '0;
            jugadas          <= '0;
            turno_p1         <= 1'b0;
            turno_p2         <= 1'b0;
            jugada_rechazada <= 1'b0;
            tiempo_agotado   <= 1'b0;
            fin_juego        <= 1'b0;
            ganador          <= 2'b00;
        end else begin
            jugada_rechazada <= 1'b0;
            tiempo_agotado   <= 1'b0;
            if (iniciar) begin
                // Restart from any state; a coincident request is dropped.
                estado    <= TURNO_P1;
                timer     <= '0;
                tablero   <= '0;
                jugadas   <= '0;
                ganador   <= 2'b00;
                fin_juego <= 1'b0;
                turno_p1  <= 1'b1;
                turno_p2  <= 1'b0;
            end else begin
                unique case (estado)
                    TURNO_P1, TURNO_P2: begin
                        if (acepta) begin
                            for (int k = 1; k <= 9; k++) begin
                                if (jugada_cuadro == 4'(k))
                                    tablero[2*k-2 +: 2] <= codigo;
                            end
                            jugadas  <= jugadas + 4'd1;
                            mover    <= codigo;
                            estado   <= EVALUA;
                            turno_p1 <= 1'b0;
                            turno_p2 <= 1'b0;
                        end else begin
                            if (jugada_valida) jugada_rechazada <= 1'b1;
                            if (fin_turno) begin
                                // Accepted move above has priority over this.
                                timer          <= '0;
                                tiempo_agotado <= 1'b1;
                                if (estado == TURNO_P1) begin
                                    estado   <= TURNO_P2;
                                    turno_p1 <= 1'b0;
                                    turno_p2 <= 1'b1;
                                end else begin
                                    estado   <= TURNO_P1;
                                    turno_p1 <= 1'b1;
                                    turno_p2 <= 1'b0;
                                end
                            end else begin
                                timer <= timer + CNT_W'(1);
                            end
                        end
                    end
                    EVALUA: begin
                        if (gana(tablero, mover)) begin
                            estado    <= FIN;
                            ganador   <= mover;
                            fin_juego <= 1'b1;
                        end else if (jugadas == 4'd9) begin
                            estado    <= FIN;
                            ganador   <= 2'b10;
                            fin_juego <= 1'b1;
                        end else begin
                            timer <= '0;
                            if (mover == 2'b11) begin
                                estado   <= TURNO_P2;
                                turno_p2 <= 1'b1;
                            end else begin
                                estado   <= TURNO_P1;
                                turno_p1 <= 1'b1;
                            end
                        end
                    end
                    ESPERA, FIN: ;
                    default: ;
                endcase
            end
        end
    end

endmodule
